// File: rtl/h_ram_pkg.sv
// Shared types and defaults for the sparse-index h RAM arbiter.
package h_ram_pkg;

  localparam int unsigned H_ADDR_W    = 7;
  localparam int unsigned H_DAT_W     = 14;
  localparam int unsigned DEF_ENTRIES = 67;

  typedef enum logic [2:0] {
    StIdle,
    StGGen,
    StGMul,
    StGHost,
    StTurn
  } state_e;

  localparam logic [1:0] GEN  = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] HOST = 2'd2;

endpackage

// File: rtl/h_ram_arb_if.sv
// Requester and RAM-side signals of the h RAM arbiter; slave is the arbiter's view.
interface h_ram_arb_if;
  import h_ram_pkg::*;

  logic                gen_req;
  logic                gen_gnt;
  logic                gen_done;
  logic [H_ADDR_W-1:0] gen_addra;
  logic                gen_wea;
  logic [H_DAT_W-1:0]  gen_douta;
  logic [H_ADDR_W-1:0] gen_addrb;
  logic                gen_web;
  logic [H_DAT_W-1:0]  gen_doutb;
  logic [H_DAT_W-1:0]  gen_dina;
  logic [H_DAT_W-1:0]  gen_dinb;

  logic                mul_req;
  logic                mul_gnt;
  logic                mul_re;
  logic [H_ADDR_W-1:0] mul_addr;
  logic [H_DAT_W-1:0]  mul_rdata;
  logic                mul_rvalid;

  logic                host_req;
  logic                host_gnt;
  logic                host_re;
  logic [H_ADDR_W-1:0] host_addr;
  logic [H_DAT_W-1:0]  host_rdata;
  logic                host_rvalid;

  logic [H_ADDR_W-1:0] ram_addra;
  logic                ram_wea;
  logic [H_DAT_W-1:0]  ram_wdata_a;
  logic [H_DAT_W-1:0]  ram_rdata_a;
  logic [H_ADDR_W-1:0] ram_addrb;
  logic                ram_web;
  logic [H_DAT_W-1:0]  ram_wdata_b;
  logic [H_DAT_W-1:0]  ram_rdata_b;

  logic                h_valid;
  logic                busy;
  logic                err_oob;

  modport slave (
    input  gen_req, gen_done, gen_addra, gen_wea, gen_douta, gen_addrb, gen_web, gen_doutb,
    output gen_gnt, gen_dina, gen_dinb,
    input  mul_req, mul_re, mul_addr,
    output mul_gnt, mul_rdata, mul_rvalid,
    input  host_req, host_re, host_addr,
    output host_gnt, host_rdata, host_rvalid,
    output ram_addra, ram_wea, ram_wdata_a, ram_addrb, ram_web, ram_wdata_b,
    input  ram_rdata_a, ram_rdata_b,
    output h_valid, busy, err_oob
  );

  modport master (
    output gen_req, gen_done, gen_addra, gen_wea, gen_douta, gen_addrb, gen_web, gen_doutb,
    input  gen_gnt, gen_dina, gen_dinb,
    output mul_req, mul_re, mul_addr,
    input  mul_gnt, mul_rdata, mul_rvalid,
    output host_req, host_re, host_addr,
    input  host_gnt, host_rdata, host_rvalid,
    input  ram_addra, ram_wea, ram_wdata_a, ram_addrb, ram_web, ram_wdata_b,
    output ram_rdata_a, ram_rdata_b,
    input  h_valid, busy, err_oob
  );

endinterface

// File: rtl/h_rr_pick2.sv
// Two-way round-robin picker: on a tie rr=0 favours req0, rr=1 favours req1.
module h_rr_pick2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_rr,
  output logic o_gnt0,
  output logic o_gnt1,
  output logic o_rr_nxt
);

  assign o_gnt0   = i_req0 & (~i_req1 | ~i_rr);
  assign o_gnt1   = i_req1 & (~i_req0 | i_rr);
  assign o_rr_nxt = (o_gnt0 | o_gnt1) ? ~i_rr : i_rr;

endmodule

// File: rtl/h_ram_arb.sv
// Arbitrates the dual-port h index RAM between generator, multiplier and host with
// whole-transaction grants, a one-cycle turnaround and out-of-range write suppression.
module h_ram_arb
  import h_ram_pkg::*;
#(
  parameter int unsigned ENTRIES = DEF_ENTRIES
) (
  input logic        clk,
  input logic        rst,
  h_ram_arb_if.slave bus
);

  localparam logic [H_ADDR_W:0] EntriesLim = (H_ADDR_W + 1)'(ENTRIES);

  state_e r_state;
  logic   r_gen_gnt, r_mul_gnt, r_host_gnt;
  logic   r_mul_rvalid, r_host_rvalid;
  logic   r_h_valid, r_err_oob, r_rr;

  logic   w_mul_elig, w_host_elig;
  logic   w_pick_mul, w_pick_host, w_rr_nxt;
  logic   w_oob_a, w_oob_b;

  logic [H_ADDR_W-1:0] w_addra, w_addrb;
  logic                w_wea, w_web;
  logic [H_DAT_W-1:0]  w_wdata_a, w_wdata_b;

  assign w_mul_elig  = r_h_valid & bus.mul_req;
  assign w_host_elig = bus.host_req;
  assign w_oob_a     = {1'b0, bus.gen_addra} >= EntriesLim;
  assign w_oob_b     = {1'b0, bus.gen_addrb} >= EntriesLim;

  h_rr_pick2 u_pick (
    .i_req0   (w_mul_elig),
    .i_req1   (w_host_elig),
    .i_rr     (r_rr),
    .o_gnt0   (w_pick_mul),
    .o_gnt1   (w_pick_host),
    .o_rr_nxt (w_rr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_gen_gnt     <= 1'b0;
      r_mul_gnt     <= 1'b0;
      r_host_gnt    <= 1'b0;
      r_mul_rvalid  <= 1'b0;
      r_host_rvalid <= 1'b0;
      r_h_valid     <= 1'b0;
      r_err_oob     <= 1'b0;
      r_rr          <= 1'b0;
    end else begin
      r_mul_rvalid  <= bus.mul_re & r_mul_gnt;
      r_host_rvalid <= bus.host_re & r_host_gnt;
      if ((r_state == StGGen) && ((bus.gen_wea && w_oob_a) || (bus.gen_web && w_oob_b))) begin
        r_err_oob <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (bus.gen_req) begin
            r_state   <= StGGen;
            r_gen_gnt <= 1'b1;
            r_h_valid <= 1'b0;
          end else if (w_pick_mul) begin
            r_state   <= StGMul;
            r_mul_gnt <= 1'b1;
            r_rr      <= w_rr_nxt;
          end else if (w_pick_host) begin
            r_state    <= StGHost;
            r_host_gnt <= 1'b1;
            r_rr       <= w_rr_nxt;
          end
        end
        StGGen: begin
          if (bus.gen_done) r_h_valid <= 1'b1;
          if (!bus.gen_req) begin
            r_state   <= StTurn;
            r_gen_gnt <= 1'b0;
          end
        end
        StGMul: begin
          if (!bus.mul_req) begin
            r_state   <= StTurn;
            r_mul_gnt <= 1'b0;
          end
        end
        StGHost: begin
          if (!bus.host_req) begin
            r_state    <= StTurn;
            r_host_gnt <= 1'b0;
          end
        end
        StTurn:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Read owners only drive port A; port B belongs to the generator alone.
  always_comb begin
    w_addra   = '0;
    w_wea     = 1'b0;
    w_wdata_a = '0;
    w_addrb   = '0;
    w_web     = 1'b0;
    w_wdata_b = '0;
    unique case (r_state)
      StGGen: begin
        w_addra   = bus.gen_addra;
        w_wea     = bus.gen_wea & ~w_oob_a;
        w_wdata_a = bus.gen_douta;
        w_addrb   = bus.gen_addrb;
        w_web     = bus.gen_web & ~w_oob_b;
        w_wdata_b = bus.gen_doutb;
      end
      StGMul:  w_addra = bus.mul_addr;
      StGHost: w_addra = bus.host_addr;
      default: ;
    endcase
  end

  assign bus.ram_addra   = w_addra;
  assign bus.ram_wea     = w_wea;
  assign bus.ram_wdata_a = w_wdata_a;
  assign bus.ram_addrb   = w_addrb;
  assign bus.ram_web     = w_web;
  assign bus.ram_wdata_b = w_wdata_b;

  assign bus.gen_gnt     = r_gen_gnt;
  assign bus.mul_gnt     = r_mul_gnt;
  assign bus.host_gnt    = r_host_gnt;
  assign bus.mul_rvalid  = r_mul_rvalid;
  assign bus.host_rvalid = r_host_rvalid;
  assign bus.mul_rdata   = bus.ram_rdata_a;
  assign bus.host_rdata  = bus.ram_rdata_a;
  assign bus.gen_dina    = bus.ram_rdata_a;
  assign bus.gen_dinb    = bus.ram_rdata_b;

  assign bus.h_valid     = r_h_valid;
  assign bus.busy        = (r_state != StIdle);
  assign bus.err_oob     = r_err_oob;

endmodule

// File: doc/h_ram_arb.md
Name: h_ram_arb

Overview:
- Owns the dual-port sparse-index RAM that holds the W/2 = 67 positions of one sparse polynomial h.
- Shares the RAM between three requesters:
  - gen: the index generator, which writes and checks duplicates on both ports.
  - mul: the sparse-dense multiplier, which reads indices on port A.
  - host: debug/readout, which reads on port A.
- Grants whole-transaction ownership, muxes RAM ports to the owner, tags read returns and tracks table validity.

Parameters:
- H_ADDR_W, 7, RAM address width (depth 2^H_ADDR_W).
- H_DAT_W, 14, index width.
- ENTRIES, 67, number of valid h entries; write addresses >= ENTRIES are illegal.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- gen_req  in  1  generator ownership request, level, held for the whole transaction.
- gen_gnt  out  1  generator owns the RAM.
- gen_done  in  1  one-cycle pulse, table fully written.
- gen_addra  in  H_ADDR_W  generator port-A address.
- gen_wea  in  1  generator port-A write enable.
- gen_douta  in  H_DAT_W  generator port-A write data.
- gen_addrb  in  H_ADDR_W  generator port-B address.
- gen_web  in  1  generator port-B write enable.
- gen_doutb  in  H_DAT_W  generator port-B write data.
- gen_dina  out  H_DAT_W  RAM port-A read data to generator.
- gen_dinb  out  H_DAT_W  RAM port-B read data to generator.
- mul_req  in  1  multiplier ownership request.
- mul_gnt  out  1  multiplier grant.
- mul_re  in  1  multiplier read strobe.
- mul_addr  in  H_ADDR_W  multiplier read address.
- mul_rdata  out  H_DAT_W  multiplier read data.
- mul_rvalid  out  1  multiplier read data valid.
- host_req  in  1  host ownership request.
- host_gnt  out  1  host grant.
- host_re  in  1  host read strobe.
- host_addr  in  H_ADDR_W  host read address.
- host_rdata  out  H_DAT_W  host read data.
- host_rvalid  out  1  host read data valid.
- ram_addra  out  H_ADDR_W  RAM port-A address.
- ram_wea  out  1  RAM port-A write enable.
- ram_wdata_a  out  H_DAT_W  RAM port-A write data.
- ram_rdata_a  in  H_DAT_W  RAM port-A read data, 1-cycle latency.
- ram_addrb  out  H_ADDR_W  RAM port-B address.
- ram_web  out  1  RAM port-B write enable.
- ram_wdata_b  out  H_DAT_W  RAM port-B write data.
- ram_rdata_b  in  H_DAT_W  RAM port-B read data, 1-cycle latency.
- h_valid  out  1  table complete and readable by mul.
- busy  out  1  any grant active or turnaround in progress.
- err_oob  out  1  sticky: an illegal write was attempted and suppressed.

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE; all gnt, rvalid, h_valid, err_oob and busy are 0; rr pointer is 0.
  - RAM outputs are all 0 (we=0, addr=0).
  - Reset mid-transaction drops the grant at that edge; requesters must re-request.
- States: IDLE, G_GEN, G_MUL, G_HOST, TURN.
- IDLE priority:
  - gen_req wins.
  - Otherwise arbitrate between mul and host. mul is eligible only when h_valid=1 and mul_req=1; host is eligible whenever host_req=1.
  - If both mul and host are eligible, rr=0 picks mul and rr=1 picks host; rr toggles after each mul/host grant.
  - If only one is eligible, that one wins.
- Grant latency: a request sampled in IDLE at edge N gives gnt=1 from cycle N+1. The gnt output is registered and equals the corresponding G_* state.
- Release:
  - The owner deasserts req; on the next edge the state goes to TURN and gnt goes to 0.
  - TURN lasts exactly one cycle, then the state returns to IDLE. The earliest next grant is 3 cycles after the req drop.
  - TURN guarantees the last read issued returns to its owner before handover.
- Port mux, combinational:
  - In G_GEN, both RAM ports follow the gen_* signals.
  - In G_MUL or G_HOST, port A address follows the owner's address; wea=0; port B is idle (addr 0, web 0).
  - In all other states RAM outputs are 0.
  - Requester strobes are ignored while its gnt=0.
- Write legality: a gen write with addr >= ENTRIES is suppressed (we forced to 0) and err_oob is set sticky. err_oob clears only on rst. Reads are never checked.
- Read return:
  - mul_rvalid is mul_re & mul_gnt registered, one cycle after the strobe. host_rvalid is the same for the host.
  - mul_rdata and host_rdata are ram_rdata_a passed through.
  - gen_dina and gen_dinb are ram_rdata_a and ram_rdata_b passed through, with no tagging, so the generator keeps its 1-cycle read timing.
- h_valid:
  - Cleared at the edge entering G_GEN.
  - Set at the edge where gen_done=1 while in G_GEN, including the cycle in which gen_req drops.
  - gen_done outside G_GEN is ignored.
- A mul_req held while h_valid=0 waits in IDLE; host may be granted meanwhile.
- gen_req during a mul/host ownership waits; there is no preemption.
- busy = state != IDLE.

Decomposition:
- Package h_ram_pkg:
  - State encoding.
  - ENTRIES, H_ADDR_W and H_DAT_W defaults.
  - Requester id constants GEN, MUL, HOST.
- Sub-module h_rr_pick2: 2-way round-robin picker (inputs req0, req1, rr; outputs gnt0, gnt1, next rr), used for the mul/host choice.

Test Plan:
- rst, gen_req=1; gen writes addr 0..66 with data = addr+100, then pulses gen_done and drops req -> gen_gnt=1 one cycle after req; h_valid rises the cycle after gen_done; TURN observed; busy=0 two cycles after the req drop.
- mul_req=1 with h_valid=0 and host_req=1 -> host granted, mul waits; after gen completes, mul reads addr 5 -> mul_rdata=105 with mul_rvalid 1 cycle later.
- mul_req and host_req both held in IDLE, each holding 4 cycles, repeated 3 times -> grant order mul, host, mul, host, and never two gnts high at once.
- gen write to addr 67 and addr 127 -> ram_wea=0 both times, err_oob=1 and stays 1 until rst.
- Host issues a read on its last owned cycle, then releases while mul_req is pending -> host_rvalid=1 during TURN; mul_rvalid is never asserted with host data.
- rst asserted mid-G_MUL -> mul_gnt=0, h_valid=0, err_oob=0 at the next edge; re-request is granted normally.
